// File: rtl/ovl_pkg.sv
// Shared types and helpers for the cross-hair overlay cursor controller.
package ovl_pkg;

  typedef logic [9:0] coord_t;
  typedef logic [1:0] color_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;
  localparam int LINE_TH_DEF = 2;

  // Move one coordinate by dir*step in 12-bit signed space and saturate to [lo, hi].
  function automatic coord_t step_clamp(coord_t pos, logic signed [1:0] dir,
                                        int step, int lo, int hi);
    logic signed [11:0] sum;
    logic signed [11:0] delta;
    logic signed [11:0] loS;
    logic signed [11:0] hiS;
    loS = 12'(lo);
    hiS = 12'(hi);
    if (dir == 2'sb01) begin
      delta = 12'(step);
    end else if (dir == 2'sb11) begin
      delta = -12'(step);
    end else begin
      delta = '0;
    end
    sum = $signed({2'b00, pos}) + delta;
    if (sum < loS) begin
      return coord_t'(loS);
    end else if (sum > hiS) begin
      return coord_t'(hiS);
    end
    return coord_t'(sum);
  endfunction

endpackage

// File: rtl/ovl_btn_sync.sv
// Two-flop synchroniser for one raw button level, plus a rising-edge detector
// on the synchronised level.
module ovl_btn_sync
  import ovl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Metastability chain followed by a one-cycle history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/overlay_cursor_ctrl.sv
// Cross-hair cursor controller: buttons -> working position/enable/colour,
// published to the overlay only on frame_start so nothing tears mid-frame.
// Optional build macro OVL_SNAP_CENTER_EN: holding up+down for a full repeat
// delay snaps the cursor back to the screen centre.
module overlay_cursor_ctrl
  import ovl_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int LINE_TH    = LINE_TH_DEF,
  parameter int STEP       = 4,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_mode,
  input  logic       frame_start,
  output logic [9:0] center_x,
  output logic [9:0] center_y,
  output logic       overlay_en,
  output logic [1:0] color_idx,
  output logic       pending
);

  localparam int               CNT_W    = $clog2(REPEAT_DLY + 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);
  localparam coord_t           X_MID    = coord_t'(H_RES / 2);
  localparam coord_t           Y_MID    = coord_t'(V_RES / 2);
  localparam int               X_MAX    = H_RES - 1 - LINE_TH;
  localparam int               Y_MAX    = V_RES - 1 - LINE_TH;

  logic rstMeta_q;
  logic rstSync_q;
  logic rstInt_n;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstMeta_q <= 1'b0;
      rstSync_q <= 1'b0;
    end else begin
      rstMeta_q <= 1'b1;
      rstSync_q <= rstMeta_q;
    end
  end

  assign rstInt_n = rstSync_q;

  logic       upLvl, downLvl, leftLvl, rightLvl;
  logic       modeRise;
  logic [3:0] unusedDirRise;
  logic       unusedModeLvl;

  ovl_btn_sync u_sync_up (
    .clk(clk), .rst_n(rstInt_n), .btn_i(btn_up),
    .level_o(upLvl), .rise_o(unusedDirRise[0])
  );
  ovl_btn_sync u_sync_down (
    .clk(clk), .rst_n(rstInt_n), .btn_i(btn_down),
    .level_o(downLvl), .rise_o(unusedDirRise[1])
  );
  ovl_btn_sync u_sync_left (
    .clk(clk), .rst_n(rstInt_n), .btn_i(btn_left),
    .level_o(leftLvl), .rise_o(unusedDirRise[2])
  );
  ovl_btn_sync u_sync_right (
    .clk(clk), .rst_n(rstInt_n), .btn_i(btn_right),
    .level_o(rightLvl), .rise_o(unusedDirRise[3])
  );
  ovl_btn_sync u_sync_mode (
    .clk(clk), .rst_n(rstInt_n), .btn_i(btn_mode),
    .level_o(unusedModeLvl), .rise_o(modeRise)
  );

  logic signed [1:0] dx, dy;
  logic              anyDir;
  logic              upDown;
  logic              moveActive;

  assign dx = (rightLvl & ~leftLvl) ? 2'sb01 : (leftLvl & ~rightLvl) ? 2'sb11 : 2'sb00;
  assign dy = (downLvl & ~upLvl)    ? 2'sb01 : (upLvl & ~downLvl)    ? 2'sb11 : 2'sb00;
  assign anyDir = upLvl | downLvl | leftLvl | rightLvl;
  assign upDown = upLvl & downLvl;
`ifdef OVL_SNAP_CENTER_EN
  assign moveActive = (dx != 2'sb00) || (dy != 2'sb00) || upDown;
`else
  assign moveActive = (dx != 2'sb00) || (dy != 2'sb00);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             doStep;
  logic             doSnap;
`ifdef OVL_SNAP_CENTER_EN
  logic             udFull_q, udFull_d;
  logic             snapHold_q, snapHold_d;
`endif

  // Hold-timing state register.
  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
`ifdef OVL_SNAP_CENTER_EN
      udFull_q   <= 1'b0;
      snapHold_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
`ifdef OVL_SNAP_CENTER_EN
      udFull_q   <= udFull_d;
      snapHold_q <= snapHold_d;
`endif
    end
  end

  // Immediate step on press, then one step after the delay and every period after that.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    doStep  = 1'b0;
    doSnap  = 1'b0;
`ifdef OVL_SNAP_CENTER_EN
    udFull_d   = udFull_q;
    snapHold_d = snapHold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (moveActive) begin
          doStep  = 1'b1;
          cnt_d   = '0;
          state_d = DELAY;
`ifdef OVL_SNAP_CENTER_EN
          udFull_d   = upDown;
          snapHold_d = 1'b0;
`endif
        end
      end
      DELAY: begin
        if (!moveActive) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DLY_LAST) begin
          doStep  = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`ifdef OVL_SNAP_CENTER_EN
        if (!upDown) begin
          udFull_d = 1'b0;
        end
        if (snapHold_q) begin
          doStep  = 1'b0;
          cnt_d   = '0;
          state_d = upDown ? DELAY : IDLE;
          if (!upDown) begin
            snapHold_d = 1'b0;
          end
        end else if (moveActive && cnt_q == DLY_LAST && udFull_q && upDown) begin
          doStep     = 1'b0;
          doSnap     = 1'b1;
          snapHold_d = 1'b1;
          state_d    = DELAY;
        end
`endif
      end
      REPEAT: begin
        if (!moveActive) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == PER_LAST) begin
          doStep = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  coord_t     workX_q, workX_d, workY_q, workY_d;
  logic       workEn_q, workEn_d;
  color_idx_t workCol_q, workCol_d;
  coord_t     pubX_q, pubX_d, pubY_q, pubY_d;
  logic       pubEn_q, pubEn_d;
  color_idx_t pubCol_q, pubCol_d;

  // Working-state updates from steps and mode presses, and shadow load on frame_start.
  always_comb begin
    workX_d   = workX_q;
    workY_d   = workY_q;
    workEn_d  = workEn_q;
    workCol_d = workCol_q;
    if (doStep) begin
      workX_d = step_clamp(workX_q, dx, STEP, LINE_TH, X_MAX);
      workY_d = step_clamp(workY_q, dy, STEP, LINE_TH, Y_MAX);
    end
    if (doSnap) begin
      workX_d = X_MID;
      workY_d = Y_MID;
    end
    if (modeRise) begin
      workEn_d = ~workEn_q;
      if (!anyDir) begin
        workCol_d = workCol_q + color_idx_t'(1);
      end
    end
    pubX_d   = frame_start ? workX_d   : pubX_q;
    pubY_d   = frame_start ? workY_d   : pubY_q;
    pubEn_d  = frame_start ? workEn_d  : pubEn_q;
    pubCol_d = frame_start ? workCol_d : pubCol_q;
  end

  // Working and published registers.
  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      workX_q   <= X_MID;
      workY_q   <= Y_MID;
      workEn_q  <= 1'b1;
      workCol_q <= '0;
      pubX_q    <= X_MID;
      pubY_q    <= Y_MID;
      pubEn_q   <= 1'b1;
      pubCol_q  <= '0;
    end else begin
      workX_q   <= workX_d;
      workY_q   <= workY_d;
      workEn_q  <= workEn_d;
      workCol_q <= workCol_d;
      pubX_q    <= pubX_d;
      pubY_q    <= pubY_d;
      pubEn_q   <= pubEn_d;
      pubCol_q  <= pubCol_d;
    end
  end

  assign center_x   = pubX_q;
  assign center_y   = pubY_q;
  assign overlay_en = pubEn_q;
  assign color_idx  = pubCol_q;
  assign pending    = (workX_q != pubX_q) || (workY_q != pubY_q) ||
                      (workEn_q != pubEn_q) || (workCol_q != pubCol_q);

endmodule

// File: tb/tb_overlay_cursor_ctrl.sv
// Self-checking bench for overlay_cursor_ctrl (default build, snap feature off).
// A behavioural model tracks how long a move has been held and derives step
// instants from that, independent of the controller's state machine.
module tb_overlay_cursor_ctrl;

  localparam int DLY = 10;
  localparam int PER = 4;
  localparam int STP = 4;

  localparam logic [4:0] B_UP    = 5'b00001;
  localparam logic [4:0] B_DOWN  = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b01000;
  localparam logic [4:0] B_MODE  = 5'b10000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_mode = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] center_x, center_y;
  logic       overlay_en;
  logic [1:0] color_idx;
  logic       pending;

  int cmpCount = 0;
  int failCount = 0;
  bit checkEn = 1'b0;

  // Model state: working and published fields, hold duration, button history.
  int         mX, mY, mEn, mCol, pX, pY, pEn, pCol;
  int         held;
  int         skip;
  logic [4:0] d1, d2, d3;

  always #5 clk = ~clk;

  overlay_cursor_ctrl #(
    .STEP(STP), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_mode(btn_mode), .frame_start(frame_start),
    .center_x(center_x), .center_y(center_y), .overlay_en(overlay_en),
    .color_idx(color_idx), .pending(pending)
  );

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic checkOutput(string name, int act, int exp);
    cmpCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mX = 320; mY = 240; mEn = 1; mCol = 0;
    pX = 320; pY = 240; pEn = 1; pCol = 0;
    held = -1;
    d1 = '0; d2 = '0; d3 = '0;
  endtask

  // One clock of behaviour; buttons are seen two clocks after they are driven.
  task automatic modelStep();
    logic [4:0] lvl, prv;
    int  dx, dy;
    bit  stepNow;
    lvl = d2;
    prv = d3;
    dx = int'(lvl[3]) - int'(lvl[2]);
    dy = int'(lvl[1]) - int'(lvl[0]);
    stepNow = 1'b0;
    if (dx != 0 || dy != 0) begin
      held = held + 1;
      stepNow = (held == 0) || (held == DLY) ||
                (held > DLY && ((held - DLY) % PER) == 0);
    end else begin
      held = -1;
    end
    if (stepNow) begin
      mX = clampi(mX + dx * STP, 2, 637);
      mY = clampi(mY + dy * STP, 2, 477);
    end
    if (lvl[4] && !prv[4]) begin
      mEn = 1 - mEn;
      if (lvl[3:0] == 4'b0000) mCol = (mCol + 1) % 4;
    end
    if (frame_start) begin
      pX = mX; pY = mY; pEn = mEn; pCol = mCol;
    end
    d3 = d2;
    d2 = d1;
    d1 = {btn_mode, btn_right, btn_left, btn_down, btn_up};
  endtask

  // Reference model advances on every clock; reset clears it at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelReset();
      skip = 2;
    end else if (skip > 0) begin
      skip = skip - 1;
    end else begin
      modelStep();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checkEn && rst_n) begin
      checkOutput("center_x", int'(center_x), pX);
      checkOutput("center_y", int'(center_y), pY);
      checkOutput("overlay_en", int'(overlay_en), pEn);
      checkOutput("color_idx", int'(color_idx), pCol);
      checkOutput("pending", int'(pending),
                  int'((mX != pX) || (mY != pY) || (mEn != pEn) || (mCol != pCol)));
    end
  end

  task automatic applyStimulus(logic [4:0] b, logic fs, int n);
    {btn_mode, btn_right, btn_left, btn_down, btn_up} = b;
    frame_start = fs;
    repeat (n) @(negedge clk);
  endtask

  task automatic publish();
    applyStimulus(5'b0, 1'b0, 4);
    applyStimulus(5'b0, 1'b1, 1);
    frame_start = 1'b0;
  endtask

  task automatic checkResetValues(string tag);
    checkOutput({tag, "_x"}, int'(center_x), 320);
    checkOutput({tag, "_y"}, int'(center_y), 240);
    checkOutput({tag, "_en"}, int'(overlay_en), 1);
    checkOutput({tag, "_col"}, int'(color_idx), 0);
    checkOutput({tag, "_pend"}, int'(pending), 0);
  endtask

  initial begin
    logic [4:0] b;
    logic       fs;
    int         len;

    repeat (3) @(negedge clk);
    checkResetValues("rst");
    rst_n = 1'b1;
    checkEn = 1'b1;
    applyStimulus(5'b0, 1'b0, 4);
    checkResetValues("post_rst");

    // Short press: exactly one step, held back until frame_start.
    applyStimulus(B_RIGHT, 1'b0, 3);
    applyStimulus(5'b0, 1'b0, 4);
    checkOutput("pulse_pend_pre", int'(pending), 1);
    checkOutput("pulse_x_pre", int'(center_x), 320);
    applyStimulus(5'b0, 1'b1, 1);
    frame_start = 1'b0;
    checkOutput("pulse_x_pub", int'(center_x), 324);
    checkOutput("pulse_pend_pub", int'(pending), 0);

    // 30-cycle hold: steps at 0, 10, 14, 18, 22, 26.
    applyStimulus(B_RIGHT, 1'b0, 30);
    publish();
    checkOutput("hold_x", int'(center_x), 348);

    // Saturation at the low and high edges.
    applyStimulus(B_LEFT | B_UP, 1'b0, 400);
    publish();
    checkOutput("clamp_lo_x", int'(center_x), 2);
    checkOutput("clamp_lo_y", int'(center_y), 2);
    applyStimulus(B_RIGHT | B_DOWN, 1'b0, 700);
    publish();
    checkOutput("clamp_hi_x", int'(center_x), 637);
    checkOutput("clamp_hi_y", int'(center_y), 477);

    // Mode presses: one toggles enable and bumps colour; four wrap back.
    applyStimulus(B_MODE, 1'b0, 2);
    publish();
    checkOutput("mode1_en", int'(overlay_en), 0);
    checkOutput("mode1_col", int'(color_idx), 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(B_MODE, 1'b0, 2);
      applyStimulus(5'b0, 1'b0, 2);
    end
    publish();
    checkOutput("mode4_en", int'(overlay_en), 1);
    checkOutput("mode4_col", int'(color_idx), 0);

    // Random button patterns with sparse frame_start pulses.
    for (int i = 0; i < 150; i++) begin
      b = '0;
      for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 2) == 0);
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        fs = ($urandom_range(0, 7) == 0);
        applyStimulus(b, fs, 1);
      end
    end
    publish();

    // Asynchronous reset while auto-repeating, button still held afterwards.
    applyStimulus(B_RIGHT, 1'b0, 20);
    #2 rst_n = 1'b0;
    #1 checkResetValues("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(B_RIGHT, 1'b0, 15);
    publish();
    checkOutput("fresh_press_x", int'(center_x), 328);

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
